// File: rtl/list_sum_pkg.sv
// Shared types and constants for the list-sum job scheduler.
//   sched_state_t : scheduler FSM state encoding
//   JOBS_CNT_W    : width of the completed-jobs counter
package list_sum_pkg;

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_run    = 2'd1,
    st_result = 2'd2
  } sched_state_t;

  localparam int JOBS_CNT_W = 16;

endpackage

// File: rtl/list_sum_scheduler_job_fifo.sv
// job_fifo: small synchronous FIFO holding list head pointers.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop, dout  : read request and head-of-queue data; ignored while empty
//   full/empty : derived from the occupancy count
// There is no bypass path: a word written into an empty FIFO appears on
// dout (and empty drops) in the following cycle.
module job_fifo
  import list_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/list_sum_scheduler.sv
// list_sum_scheduler: queues list head pointers and runs the linked-list
// summation engine once per job, returning a sum or a timeout flag.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   job_valid/job_ready   : producer job port, job_head is the list head
//   res_valid/res_ready   : result port with res_sum, res_head, res_timeout
//   eng_start, eng_head   : level start and head pointer to the engine
//   eng_done, eng_sum     : engine completion flag and sum
//   busy                  : a job is in flight or queued
//   jobs_done             : wrapping count of completed jobs (incl. timeouts)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until the
// transfer; job_ready is simply "queue not full" and does not depend on
// job_valid; res_valid stays high with a stable payload until res_ready.
module list_sum_scheduler
  import list_sum_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_W-1:0]     job_head,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_sum,
  output logic [ADDR_W-1:0]     res_head,
  output logic                  res_timeout,
  output logic                  eng_start,
  output logic [ADDR_W-1:0]     eng_head,
  input  logic                  eng_done,
  input  logic [DATA_W-1:0]     eng_sum,
  output logic                  busy,
  output logic [JOBS_CNT_W-1:0] jobs_done
);

  // The counter must also hold TIMEOUT itself after the final increment.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

  sched_state_t          state_q;
  sched_state_t          state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [JOBS_CNT_W-1:0] jobs_cnt_q;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_W-1:0]     fifo_dout;

  // Jobs leave the queue only on the IDLE to RUN transition.
  assign fifo_pop = (state_q == st_idle) && !fifo_empty;

  job_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid),
    .pop   (fifo_pop),
    .din   (job_head),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic. eng_done only matters in RUN; the engine's done flag
  // lingers for a cycle after start drops and lands harmlessly in RESULT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (!fifo_empty) begin
          state_d = st_run;
        end
      end
      st_run: begin
        if (eng_done || (cnt_q == LAST_CNT)) begin
          state_d = st_result;
        end
      end
      st_result: begin
        if (res_ready) begin
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= st_idle;
      cnt_q       <= '0;
      eng_start   <= 1'b0;
      eng_head    <= '0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_head    <= '0;
      res_timeout <= 1'b0;
      jobs_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      // Outputs are registered from the next state so they line up with it.
      eng_start <= (state_d == st_run);
      res_valid <= (state_d == st_result);
      case (state_q)
        st_idle: begin
          if (fifo_pop) begin
            eng_head <= fifo_dout;
            cnt_q    <= '0;
          end
        end
        st_run: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (state_d == st_result) begin
            // Done beats timeout when both land in the same cycle.
            res_sum     <= eng_done ? eng_sum : '0;
            res_head    <= eng_head;
            res_timeout <= !eng_done;
          end
        end
        st_result: begin
          if (res_ready) begin
            jobs_cnt_q <= jobs_cnt_q + JOBS_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign job_ready = !fifo_full;
  assign busy      = (state_q != st_idle) || !fifo_empty;
  assign jobs_done = jobs_cnt_q;

endmodule

// File: tb/tb_list_sum_scheduler.sv
// Self-checking bench for list_sum_scheduler with a behavioural engine.
// The engine returns sum = head ^ 0x3A after eng_lat RUN cycles, or never.
module tb_list_sum_scheduler;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int RES_W   = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [ADDR_W-1:0] job_head = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_sum;
  logic [ADDR_W-1:0] res_head;
  logic              res_timeout;
  logic              eng_start;
  logic [ADDR_W-1:0] eng_head;
  logic              eng_done;
  logic [DATA_W-1:0] eng_sum;
  logic              busy;
  logic [15:0]       jobs_done;

  always #5 clk = ~clk;

  list_sum_scheduler #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_head    (job_head),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_head    (res_head),
    .res_timeout (res_timeout),
    .eng_start   (eng_start),
    .eng_head    (eng_head),
    .eng_done    (eng_done),
    .eng_sum     (eng_sum),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  // ---------------- engine model ----------------
  int eng_lat   = 5;
  bit eng_never = 1'b0;
  int ecnt;

  assign eng_sum = eng_head ^ 8'h3A;

  // Done is registered, holds while start is high, and lingers one cycle
  // after start drops, like the real engine.
  always @(posedge clk) begin
    if (rst) begin
      ecnt     <= 0;
      eng_done <= 1'b0;
    end else if (eng_start) begin
      ecnt <= ecnt + 1;
      if (!eng_never && ecnt == eng_lat - 1) eng_done <= 1'b1;
    end else begin
      ecnt     <= 0;
      eng_done <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [15:0]      exp_jobs = '0;
  int               n_tests = 0;
  int               n_fail  = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge, return at one) ----
  task automatic push_job(input logic [ADDR_W-1:0] h, output bit accepted);
    job_valid = 1'b1;
    job_head  = h;
    accepted  = job_ready;
    if (accepted) begin
      if (eng_never || eng_lat > TIMEOUT - 1)
        exp_q.push_back({1'b1, h, 8'h00});
      else
        exp_q.push_back({1'b0, h, h ^ 8'h3A});
    end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({res_valid, eng_start, busy, res_timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {res_valid, eng_start, busy, res_timeout});
    end
    n_tests++;
    if (job_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_job_ready: got %b required 1", job_ready);
    end
    n_tests++;
    if ({res_sum, res_head, eng_head, jobs_done} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {res_sum, res_head, eng_head, jobs_done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit acc;
    int w;
    logic [RES_W-1:0] exp;
    eng_lat = 5;
    res_ready = 1'b0;
    push_job(8'h10, acc);
    n_tests++;
    if (eng_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start_early: got %b required 0", eng_start);
    end
    @(negedge clk);
    n_tests++;
    if ({eng_start, busy, eng_head} !== {2'b11, 8'h10}) begin
      n_fail++;
      $display("FAIL single_start: got start=%b busy=%b head=%h required 1 1 10", eng_start, busy, eng_head);
    end
    w = 0;
    while (!res_valid && w < 40) begin @(negedge clk); w++; end
    n_tests++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if ({res_valid, eng_start, res_timeout, res_head, res_sum} !== {2'b10, exp}) begin
      n_fail++;
      $display("FAIL single_result: got v=%b s=%b %h required 1 0 %h", res_valid, eng_start,
               {res_timeout, res_head, res_sum}, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_jobs++;
    n_tests++;
    if ({res_valid, busy, jobs_done} !== {2'b00, exp_jobs}) begin
      n_fail++;
      $display("FAIL single_after: got v=%b busy=%b jobs=%h required 0 0 %h", res_valid, busy, jobs_done, exp_jobs);
    end
  endtask

  task automatic test_queue_full();
    bit acc;
    int w;
    logic [RES_W-1:0] exp;
    eng_lat = 1;
    res_ready = 1'b0;
    push_job(8'($urandom_range(0, 255)), acc);
    w = 0;
    while (!res_valid && w < 20) begin @(negedge clk); w++; end
    // Scheduler is parked in RESULT, so the queue fills to its depth.
    for (int i = 0; i < 5; i++) begin
      push_job(8'($urandom_range(0, 255)), acc);
      n_tests++;
      if (acc !== (i < DEPTH)) begin
        n_fail++;
        $display("FAIL queue_ready_%0d: got %b required %b", i, acc, (i < DEPTH));
      end
    end
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!res_valid && w < 40) begin @(negedge clk); w++; end
      n_tests++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if ({res_valid, res_timeout, res_head, res_sum} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL queue_result_%0d: got v=%b %h required 1 %h", k, res_valid,
                 {res_timeout, res_head, res_sum}, exp);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_jobs++;
    end
    n_tests++;
    if ({busy, jobs_done} !== {1'b0, exp_jobs}) begin
      n_fail++;
      $display("FAIL queue_jobs: got busy=%b jobs=%h required 0 %h", busy, jobs_done, exp_jobs);
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int w;
    int c;
    logic [RES_W-1:0] exp;
    eng_never = 1'b1;
    res_ready = 1'b0;
    push_job(8'h5C, acc);
    w = 0;
    while (!eng_start && w < 10) begin @(negedge clk); w++; end
    c = 0;
    while (eng_start && c < 40) begin @(negedge clk); c++; end
    n_tests++;
    if (c != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_run_cycles: got %0d required %0d", c, TIMEOUT);
    end
    n_tests++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if ({res_valid, eng_start, res_timeout, res_head, res_sum} !== {2'b10, exp}) begin
      n_fail++;
      $display("FAIL timeout_result: got v=%b s=%b %h required 1 0 %h", res_valid, eng_start,
               {res_timeout, res_head, res_sum}, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_jobs++;
    // Done in the last allowed cycle, then a short normal job.
    eng_never = 1'b0;
    for (int j = 0; j < 2; j++) begin
      eng_lat = (j == 0) ? TIMEOUT - 1 : 2;
      push_job(8'($urandom_range(0, 255)), acc);
      w = 0;
      while (!res_valid && w < 40) begin @(negedge clk); w++; end
      n_tests++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if ({res_valid, res_timeout, res_head, res_sum} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL timeout_next_%0d: got v=%b %h required 1 %h", j, res_valid,
                 {res_timeout, res_head, res_sum}, exp);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_jobs++;
    end
  endtask

  task automatic test_stale_done();
    bit acc;
    int seen;
    logic [RES_W-1:0] exp;
    eng_lat = 1;
    res_ready = 1'b1;
    push_job(8'hA7, acc);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        seen++;
        n_tests++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if ({res_timeout, res_head, res_sum} !== exp) begin
          n_fail++;
          $display("FAIL stale_result: got %h required %h", {res_timeout, res_head, res_sum}, exp);
        end
        exp_jobs++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    n_tests++;
    if (seen != 1 || jobs_done !== exp_jobs) begin
      n_fail++;
      $display("FAIL stale_count: got results=%0d jobs=%h required 1 %h", seen, jobs_done, exp_jobs);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int last_hs;
    logic [RES_W-1:0] exp;
    eng_lat = $urandom_range(1, 4);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_job(8'($urandom_range(0, 255)), acc);
    last_hs = -100;
    for (int c = 0; c < 80; c++) begin
      if (c == last_hs + 1) begin
        n_tests++;
        if (eng_start !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap: got eng_start=%b required 0", eng_start);
        end
      end
      if (c == last_hs + 2 && exp_q.size() > 0) begin
        n_tests++;
        if (eng_start !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart: got eng_start=%b required 1", eng_start);
        end
      end
      if (res_valid) begin
        n_tests++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if ({res_timeout, res_head, res_sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result: got %h required %h", {res_timeout, res_head, res_sum}, exp);
        end
        exp_jobs++;
        last_hs = c;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || jobs_done !== exp_jobs) begin
      n_fail++;
      $display("FAIL b2b_drain: got left=%0d jobs=%h required 0 %h", exp_q.size(), jobs_done, exp_jobs);
    end
  endtask

  task automatic test_reset_midrun();
    bit acc;
    int seen;
    eng_never = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_job(8'(8'h30 + i), acc);
    n_tests++;
    if (eng_start !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_running: got eng_start=%b required 1", eng_start);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_jobs = '0;
    n_tests++;
    if ({res_valid, eng_start, busy, job_ready, jobs_done, res_sum, res_head, eng_head} !== {4'b0001, 40'h0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got v=%b s=%b busy=%b rdy=%b data=%h required 0 0 0 1 0",
               res_valid, eng_start, busy, job_ready, {jobs_done, res_sum, res_head, eng_head});
    end
    eng_never = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid || eng_start || busy) seen++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrun_discard: got %0d active cycles required 0", seen);
    end
  endtask

  task automatic test_wrap();
    bit acc;
    int w;
    logic [RES_W-1:0] exp;
    force dut.jobs_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.jobs_cnt_q;
    exp_jobs = 16'hFFFE;
    eng_lat = 2;
    for (int j = 0; j < 2; j++) begin
      push_job(8'($urandom_range(0, 255)), acc);
      w = 0;
      while (!res_valid && w < 40) begin @(negedge clk); w++; end
      n_tests++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if ({res_valid, res_timeout, res_head, res_sum} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL wrap_result_%0d: got v=%b %h required 1 %h", j, res_valid,
                 {res_timeout, res_head, res_sum}, exp);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_jobs++;
      n_tests++;
      if (jobs_done !== exp_jobs) begin
        n_fail++;
        $display("FAIL wrap_jobs_%0d: got %h required %h", j, jobs_done, exp_jobs);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_queue_full();
    test_timeout();
    test_stale_done();
    test_back_to_back();
    test_reset_midrun();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
